// File: rtl/requantize_pkg.sv
// Shared types and constants for the requantize datapath.
package requantize_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_EVEN = 2'd2,
    RND_RSVD      = 2'd3
  } round_mode_t;

  // Largest value representable in a signed word of resw bits
  function automatic longint sat_max(input int resw);
    return (longint'(1) <<< (resw - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed word of resw bits
  function automatic longint sat_min(input int resw);
    return -(longint'(1) <<< (resw - 1));
  endfunction

endpackage

// File: rtl/requantize_pipe_stage.sv
// Valid/ready register slice: one entry, loads when empty or when downstream
// takes the held word, so a full slice still sustains one word per cycle.
module pipe_stage
  import requantize_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  // Next state: on load take whatever upstream offers; otherwise hold
  always_comb begin
    load    = !valid_q || out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  // State register; reset drops any held word
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = load;
  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/requantize.sv
// Streaming signed requantizer: shift/round stage then saturate stage.
// Optional saturation flag and event counter under REQUANTIZE_SAT_COUNT_EN.
module requantize
  import requantize_pkg::*;
#(
  parameter int ARGW  = 24,
  parameter int RESW  = 16,
  parameter int SHIFT = 0,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ARGW-1:0] arg_data,
  input  logic            arg_valid,
  output logic            arg_ready,
  input  logic [1:0]      mode,
  output logic [RESW-1:0] res_data,
  output logic            res_valid,
  input  logic            res_ready
`ifdef REQUANTIZE_SAT_COUNT_EN
  ,
  output logic            res_sat,
  output logic [CNTW-1:0] sat_count
`endif
);

  // One extra bit of headroom so the rounding add never wraps
  localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ARGW:0] ONE  = {{ARGW{1'b0}}, 1'b1};
  localparam logic signed [ARGW:0] HALF = (SHIFT > 0) ? (ONE << SH1) : '0;
  localparam logic signed [ARGW:0] MAXV = (ARGW+1)'(sat_max(RESW));
  localparam logic signed [ARGW:0] MINV = (ARGW+1)'(sat_min(RESW));

`ifdef REQUANTIZE_SAT_COUNT_EN
  localparam int S2W = RESW + 1;
`else
  localparam int S2W = RESW;
`endif

  round_mode_t           mode_e;
  logic signed [ARGW:0]  arg_ext, bias, rnd_sum, rnd_q;
  logic        [ARGW:0]  s1_data;
  logic                  s1_valid, s2_in_ready;
  logic        [RESW-1:0] sat_res;
  logic                  sat_hi, sat_lo;
  logic        [S2W-1:0] s2_in, s2_out;

  assign mode_e  = round_mode_t'(mode);
  assign arg_ext = {arg_data[ARGW-1], arg_data};

  // Rounding bias then arithmetic shift; half-even adds one less on an even LSB
  always_comb begin
    bias = '0;
    if (SHIFT > 0) begin
      case (mode_e)
        RND_HALF_UP:   bias = HALF;
        RND_HALF_EVEN: bias = HALF - ONE + {{ARGW{1'b0}}, arg_data[SHIFT]};
        default:       bias = '0;
      endcase
    end
    rnd_sum = arg_ext + bias;
    rnd_q   = rnd_sum >>> SHIFT;
  end

  pipe_stage #(.WIDTH(ARGW + 1)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (rnd_q),
    .in_valid  (arg_valid),
    .in_ready  (arg_ready),
    .out_data  (s1_data),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready)
  );

  // Clamp the rounded value into the signed result range
  always_comb begin
    sat_hi  = $signed(s1_data) > MAXV;
    sat_lo  = $signed(s1_data) < MINV;
    sat_res = s1_data[RESW-1:0];
    if (sat_hi)      sat_res = MAXV[RESW-1:0];
    else if (sat_lo) sat_res = MINV[RESW-1:0];
  end

`ifdef REQUANTIZE_SAT_COUNT_EN
  assign s2_in = {sat_hi | sat_lo, sat_res};
`else
  assign s2_in = sat_res;
`endif

  pipe_stage #(.WIDTH(S2W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (s2_in),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .out_data  (s2_out),
    .out_valid (res_valid),
    .out_ready (res_ready)
  );

  assign res_data = s2_out[RESW-1:0];

`ifdef REQUANTIZE_SAT_COUNT_EN
  logic [CNTW-1:0] sat_count_q, sat_count_d;

  assign res_sat = s2_out[RESW];

  // Count clamped words as they leave; stick at all-ones
  always_comb begin
    sat_count_d = sat_count_q;
    if (res_valid && res_ready && res_sat && !(&sat_count_q))
      sat_count_d = sat_count_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) sat_count_q <= '0;
    else     sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_requantize.sv
// Bench for requantize: SHIFT=4 and SHIFT=0 instances driven in lockstep,
// checked against an integer floor/round/clamp reference model.
module tb_requantize;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] arg_data = '0;
  logic        arg_valid = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        res_ready = 1'b1;
  logic        arg_ready, res_valid, arg_ready0, res_valid0;
  logic [15:0] res_data, res_data0;
`ifdef REQUANTIZE_SAT_COUNT_EN
  logic        res_sat, res_sat0;
  logic [15:0] sat_count, sat_count0;
`endif

  always #5 clk = ~clk;

  requantize #(.ARGW(24), .RESW(16), .SHIFT(4), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .arg_data(arg_data), .arg_valid(arg_valid),
    .arg_ready(arg_ready), .mode(mode), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready)
`ifdef REQUANTIZE_SAT_COUNT_EN
    , .res_sat(res_sat), .sat_count(sat_count)
`endif
  );

  requantize #(.ARGW(24), .RESW(16), .SHIFT(0), .CNTW(16)) dut0 (
    .clk(clk), .rst(rst), .arg_data(arg_data), .arg_valid(arg_valid),
    .arg_ready(arg_ready0), .mode(mode), .res_data(res_data0),
    .res_valid(res_valid0), .res_ready(res_ready)
`ifdef REQUANTIZE_SAT_COUNT_EN
    , .res_sat(res_sat0), .sat_count(sat_count0)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_satcnt = 0;

  logic [16:0] exp4[$], exp0[$];
  logic [15:0] got4[$], got0[$];
  logic        gsat[$];
  int          acc_cyc[$], got_cyc[$];

  // Reference: value = arg / 2^sh, rounded per mode, clamped to 16 bits.
  // Returns {clamped, result}.
  function automatic logic [16:0] model(input logic [23:0] a, input logic [1:0] m, input int sh);
    longint v, p, fl, r, q;
    logic   s;
    v  = longint'($signed(a));
    p  = longint'(1) << sh;
    fl = v / p;
    if ((v % p) != 0 && v < 0) fl = fl - 1;
    r = v - fl * p;
    q = fl;
    if (sh > 0) begin
      if (m == 2'd1 && 2 * r >= p) q = fl + 1;
      if (m == 2'd2 && (2 * r > p || (2 * r == p && (fl % 2) != 0))) q = fl + 1;
    end
    s = 1'b0;
    if (q > 32767)  begin q = 32767;  s = 1'b1; end
    if (q < -32768) begin q = -32768; s = 1'b1; end
    return {s, q[15:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitor: record expected values on accept, observed on emit
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst) begin
      exp4.delete(); exp0.delete(); got4.delete(); got0.delete(); gsat.delete();
      acc_cyc.delete(); got_cyc.delete(); exp_satcnt = 0;
    end else begin
      if (arg_valid && arg_ready) begin
        e = model(arg_data, mode, 4);
        exp4.push_back(e);
        if (e[16]) exp_satcnt++;
        exp0.push_back(model(arg_data, mode, 0));
        acc_cyc.push_back(cyc);
      end
      if (res_valid && res_ready) begin
        got4.push_back(res_data);
        got_cyc.push_back(cyc);
`ifdef REQUANTIZE_SAT_COUNT_EN
        gsat.push_back(res_sat);
`endif
      end
      if (res_valid0 && res_ready) got0.push_back(res_data0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [23:0] a, input logic [1:0] m);
    int n;
    arg_data = a; mode = m; arg_valid = 1'b1; n = 0;
    forever begin
      @(negedge clk);
      if (arg_ready) break;
      n++;
      if (n > 200) begin chk("send_timeout", 32'(n), 32'd0); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    arg_valid = 1'b0; res_ready = 1'b1; n = 0;
    while ((got4.size() < exp4.size() || got0.size() < exp0.size()) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_done", 32'(n < 100), 32'd1);
    repeat (2) @(posedge clk); #1;
  endtask

  // Compare every recorded word against the model, then clear the record
  task automatic compare_all(input string tag);
    chk({tag, "_cnt4"}, 32'(got4.size()), 32'(exp4.size()));
    chk({tag, "_cnt0"}, 32'(got0.size()), 32'(exp0.size()));
    for (int i = 0; i < exp4.size() && i < got4.size(); i++)
      chk({tag, "_s4"}, 32'(got4[i]), 32'(exp4[i][15:0]));
    for (int i = 0; i < exp0.size() && i < got0.size(); i++)
      chk({tag, "_s0"}, 32'(got0[i]), 32'(exp0[i][15:0]));
`ifdef REQUANTIZE_SAT_COUNT_EN
    for (int i = 0; i < exp4.size() && i < gsat.size(); i++)
      chk({tag, "_sat"}, 32'(gsat[i]), 32'(exp4[i][16]));
    chk({tag, "_satcnt"}, 32'(sat_count), 32'(exp_satcnt));
`endif
    exp4.delete(); exp0.delete(); got4.delete(); got0.delete(); gsat.delete();
    acc_cyc.delete(); got_cyc.delete();
  endtask

  logic [23:0] d_arg[14] = '{24'h000100, 24'h000018, 24'h000018, 24'h000018,
                             24'h000028, 24'h000028, 24'h000028,
                             24'hFFFFE8, 24'hFFFFE8, 24'hFFFFE8,
                             24'h7FFFFF, 24'h800000, 24'h0000FF, 24'hFFFF00};
  logic [1:0]  d_mode[14] = '{0, 0, 1, 2, 0, 1, 2, 0, 1, 2, 1, 0, 0, 0};
  logic [15:0] d_exp[12]  = '{16'h0010, 16'h0001, 16'h0002, 16'h0002,
                             16'h0002, 16'h0003, 16'h0002,
                             16'hFFFE, 16'hFFFF, 16'hFFFE,
                             16'h7FFF, 16'h8000};

  initial begin
    bit done;
    // Reset state
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_arg_ready", 32'(arg_ready), 32'd1);
    chk("rst_res_valid0", 32'(res_valid0), 32'd0);

    // Directed rounding/saturation vectors, streamed back to back
    res_ready = 1'b1;
    for (int i = 0; i < 14; i++) send(d_arg[i], d_mode[i]);
    drain();
    for (int i = 0; i < 12 && i < got4.size(); i++) chk("dir_s4", 32'(got4[i]), 32'(d_exp[i]));
    if (got0.size() == 14) begin
      chk("dir_s0_ff", 32'(got0[12]), 32'h00FF);
      chk("dir_s0_ff00", 32'(got0[13]), 32'hFF00);
    end else chk("dir_s0_cnt", 32'(got0.size()), 32'd14);
    for (int i = 0; i < 14 && i < got_cyc.size(); i++) begin
      chk("latency", 32'(got_cyc[i] - acc_cyc[i]), 32'd2);
      chk("throughput", 32'(acc_cyc[i] - acc_cyc[0]), 32'(i));
    end
`ifdef REQUANTIZE_SAT_COUNT_EN
    if (gsat.size() == 14) begin
      chk("dir_sat_hi", 32'(gsat[10]), 32'd1);
      chk("dir_sat_lo", 32'(gsat[11]), 32'd1);
    end
    chk("dir_sat_count", 32'(sat_count), 32'd2);
`endif
    compare_all("dir");

    // Backpressure: result side stalled while 8 words are offered
    res_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(24'(i * 16), 2'd0);
        arg_valid = 1'b0;
      end
    join_none
    repeat (5) @(posedge clk); #1;
    chk("bp_accepts", 32'(exp4.size()), 32'd2);
    chk("bp_arg_ready", 32'(arg_ready), 32'd0);
    chk("bp_no_emit", 32'(got4.size()), 32'd0);
    res_ready = 1'b1;
    wait fork;
    drain();
    chk("bp_count", 32'(got4.size()), 32'd8);
    for (int i = 0; i < 8 && i < got4.size(); i++) chk("bp_order", 32'(got4[i]), 32'(i + 1));
    compare_all("bp");

    // Reset with two words in flight
    res_ready = 1'b0;
    send(24'h000200, 2'd0);
    send(24'h000300, 2'd0);
    arg_valid = 1'b0;
    chk("mid_inflight", 32'(exp4.size()), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_data", 32'(res_data), 32'd0);
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("mid_no_stale", 32'(got4.size()), 32'd0);
    chk("mid_no_stale0", 32'(got0.size()), 32'd0);
    send(24'h000028, 2'd2);
    send(24'hFFFFE8, 2'd1);
    send(24'h123456, 2'd0);
    drain();
    compare_all("restart");

    // Random words with random result-side stalls
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [23:0] a;
          a = 24'($urandom);
          if ($urandom_range(0, 3) == 0) a = {{9{a[23]}}, a[14:0]};
          send(a, 2'($urandom_range(0, 3)));
          if ($urandom_range(0, 4) == 0) begin
            arg_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        arg_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    compare_all("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
